// File: rtl/frame_pkg.sv
// Shared constants and types for the frame reader: screen geometry,
// shadow-buffer addressing, FSM states and the pixel record.
package frame_pkg;

  localparam int unsigned SCREEN_W  = 160;
  localparam int unsigned SCREEN_H  = 120;
  localparam int unsigned PIX_COUNT = 19200;
  localparam int unsigned ADDR_W    = 15;

  typedef enum logic [1:0] {
    ST_CLEAR,
    ST_IDLE,
    ST_READ
  } state_e;

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       last;
  } pixel_t;

endpackage

// File: rtl/frame_ram.sv
// Simple dual-port shadow store: one write port, one registered read port.
// A same-address read and write in one cycle returns the old contents.
module frame_ram #(
  parameter int unsigned DEPTH  = 19200,
  parameter int unsigned ADDR_W = 15,
  parameter int unsigned DATA_W = 3
) (
  input  logic              clock,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clock) begin
    rdata_q <= mem_q[raddr_i];
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/frame_reader.sv
// Shadow framebuffer mirroring VGA plot writes, with a streaming
// rectangular region reader (valid/ready) behind a 2-entry skid buffer.
module frame_reader
  import frame_pkg::*;
#(
  parameter int unsigned SCREEN_W = frame_pkg::SCREEN_W,
  parameter int unsigned SCREEN_H = frame_pkg::SCREEN_H
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       plot,
  input  logic [7:0] x,
  input  logic [6:0] y,
  input  logic [2:0] colour,
  input  logic       rd_req,
  input  logic [7:0] rd_x0,
  input  logic [7:0] rd_w,
  input  logic [6:0] rd_y0,
  input  logic [6:0] rd_h,
  output logic       rd_ready,
  output logic       clearing,
  output logic       px_valid,
  input  logic       px_ready,
  output logic [7:0] px_x,
  output logic [6:0] px_y,
  output logic [2:0] px_colour,
  output logic       px_last
);

  localparam int unsigned PIX = SCREEN_W * SCREEN_H;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] clr_q, clr_d;
  logic [7:0]        x0_q, x0_d, w_q, w_d, ox_q, ox_d;
  logic [6:0]        y0_q, y0_d, h_q, h_d, oy_q, oy_d;
  logic              issuing_q, issuing_d;
  logic              s1_valid_q, s1_valid_d;
  logic              s1_oob_q, s1_oob_d;
  pixel_t            s1_q, s1_d;
  pixel_t            fifo_q [2];
  pixel_t            fifo_d [2];
  logic [1:0]        cnt_q, cnt_d;

  logic              ram_we;
  logic [ADDR_W-1:0] ram_waddr, ram_raddr;
  logic [2:0]        ram_wdata, ram_rdata;

  logic [8:0]        sum_x;
  logic [7:0]        sum_y;
  logic              sum_oob, rd_last, wr_ok;
  logic              valid, pop, issue;
  logic [2:0]        occ;
  pixel_t            s1_pix, head;

  frame_ram #(
    .DEPTH  (PIX),
    .ADDR_W (ADDR_W),
    .DATA_W (3)
  ) u_ram (
    .clock   (clock),
    .we_i    (ram_we),
    .waddr_i (ram_waddr),
    .wdata_i (ram_wdata),
    .raddr_i (ram_raddr),
    .rdata_o (ram_rdata)
  );

  assign sum_x   = {1'b0, x0_q} + {1'b0, ox_q};
  assign sum_y   = {1'b0, y0_q} + {1'b0, oy_q};
  assign sum_oob = (32'(sum_x) >= SCREEN_W) || (32'(sum_y) >= SCREEN_H);
  assign rd_last = (ox_q == w_q - 8'd1) && (oy_q == h_q - 7'd1);
  assign ram_raddr = sum_oob ? '0 : ADDR_W'(32'(sum_y) * SCREEN_W + 32'(sum_x));

  assign wr_ok = (32'(x) < SCREEN_W) && (32'(y) < SCREEN_H);

  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = '0;
    ram_wdata = '0;
    if (state_q == ST_CLEAR) begin
      ram_we    = 1'b1;
      ram_waddr = clr_q;
    end else if (plot && wr_ok) begin
      ram_we    = 1'b1;
      ram_waddr = ADDR_W'(32'(y) * SCREEN_W + 32'(x));
      ram_wdata = colour;
    end
  end

  // Stage 1 holds the pixel whose RAM read is in flight; it is presented
  // directly when the skid buffer is empty so the first pixel costs 2 cycles.
  always_comb begin
    s1_pix = s1_q;
    s1_pix.colour = s1_oob_q ? 3'd0 : ram_rdata;
  end

  assign valid = (cnt_q != 2'd0) || s1_valid_q;
  assign head  = (cnt_q != 2'd0) ? fifo_q[0] : s1_pix;
  assign pop   = valid && px_ready;
  assign occ   = {1'b0, cnt_q} + {2'b00, s1_valid_q};
  assign issue = (state_q == ST_READ) && issuing_q && ((occ - {2'b00, pop}) <= 3'd1);

  assign px_valid  = valid;
  assign px_x      = valid ? head.x      : '0;
  assign px_y      = valid ? head.y      : '0;
  assign px_colour = valid ? head.colour : '0;
  assign px_last   = valid ? head.last   : 1'b0;
  assign rd_ready  = (state_q == ST_IDLE);
  assign clearing  = (state_q == ST_CLEAR);

  always_comb begin
    state_d    = state_q;
    clr_d      = clr_q;
    x0_d       = x0_q;
    y0_d       = y0_q;
    w_d        = w_q;
    h_d        = h_q;
    ox_d       = ox_q;
    oy_d       = oy_q;
    issuing_d  = issuing_q;
    s1_valid_d = 1'b0;
    s1_d       = s1_q;
    s1_oob_d   = s1_oob_q;
    fifo_d     = fifo_q;
    cnt_d      = cnt_q;

    if (pop && (cnt_q != 2'd0)) begin
      fifo_d[0] = fifo_q[1];
      cnt_d     = cnt_q - 2'd1;
    end
    if (s1_valid_q && !(pop && (cnt_q == 2'd0))) begin
      fifo_d[cnt_d[0]] = s1_pix;
      cnt_d            = cnt_d + 2'd1;
    end

    case (state_q)
      ST_CLEAR: begin
        clr_d = clr_q + ADDR_W'(1);
        if (32'(clr_q) == PIX - 1) begin
          clr_d   = '0;
          state_d = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (rd_req && (rd_w != 8'd0) && (rd_h != 7'd0)) begin
          x0_d      = rd_x0;
          y0_d      = rd_y0;
          w_d       = rd_w;
          h_d       = rd_h;
          ox_d      = '0;
          oy_d      = '0;
          issuing_d = 1'b1;
          state_d   = ST_READ;
        end
      end
      ST_READ: begin
        if (issue) begin
          s1_valid_d = 1'b1;
          s1_d       = '{x: sum_x[7:0], y: sum_y[6:0], colour: 3'd0, last: rd_last};
          s1_oob_d   = sum_oob;
          if (rd_last) begin
            issuing_d = 1'b0;
          end else if (ox_q == w_q - 8'd1) begin
            ox_d = '0;
            oy_d = oy_q + 7'd1;
          end else begin
            ox_d = ox_q + 8'd1;
          end
        end
        if (pop && head.last) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_CLEAR;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q    <= ST_CLEAR;
      clr_q      <= '0;
      x0_q       <= '0;
      y0_q       <= '0;
      w_q        <= '0;
      h_q        <= '0;
      ox_q       <= '0;
      oy_q       <= '0;
      issuing_q  <= 1'b0;
      s1_valid_q <= 1'b0;
      s1_q       <= '0;
      s1_oob_q   <= 1'b0;
      fifo_q     <= '{default: '0};
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      clr_q      <= clr_d;
      x0_q       <= x0_d;
      y0_q       <= y0_d;
      w_q        <= w_d;
      h_q        <= h_d;
      ox_q       <= ox_d;
      oy_q       <= oy_d;
      issuing_q  <= issuing_d;
      s1_valid_q <= s1_valid_d;
      s1_q       <= s1_d;
      s1_oob_q   <= s1_oob_d;
      fifo_q     <= fifo_d;
      cnt_q      <= cnt_d;
    end
  end

endmodule

// File: tb/tb_frame_reader.sv
// Scoreboard bench for frame_reader: expected pixels come from a plain
// array model of the screen and are compared as the DUT hands them over.
module tb_frame_reader;

  localparam int W = 160;
  localparam int H = 120;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       plot = 1'b0;
  logic [7:0] x = '0;
  logic [6:0] y = '0;
  logic [2:0] colour = '0;
  logic       rd_req = 1'b0;
  logic [7:0] rd_x0 = '0, rd_w = '0;
  logic [6:0] rd_y0 = '0, rd_h = '0;
  logic       rd_ready, clearing, px_valid, px_ready, px_last;
  logic [7:0] px_x;
  logic [6:0] px_y;
  logic [2:0] px_colour;

  int          checks = 0;
  int          errors = 0;
  int          popped = 0;
  int          rmode = 0;
  int          tcnt = 0;
  bit          mon_en = 1'b0;
  logic [2:0]  model [W*H];
  logic [18:0] exp_q [$];

  frame_reader #(.SCREEN_W(160), .SCREEN_H(120)) dut (
    .clock(clock), .reset(reset), .plot(plot), .x(x), .y(y), .colour(colour),
    .rd_req(rd_req), .rd_x0(rd_x0), .rd_w(rd_w), .rd_y0(rd_y0), .rd_h(rd_h),
    .rd_ready(rd_ready), .clearing(clearing), .px_valid(px_valid), .px_ready(px_ready),
    .px_x(px_x), .px_y(px_y), .px_colour(px_colour), .px_last(px_last)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  // px_ready changes just after the rising edge: 0 = always 1, 1 = random, 2 = 1,0,0 repeating
  initial begin
    px_ready = 1'b1;
    forever begin
      @(posedge clock);
      #1;
      case (rmode)
        0: px_ready = 1'b1;
        1: px_ready = 1'($urandom_range(0, 1));
        default: begin
          px_ready = ((tcnt % 3) == 0);
          tcnt++;
        end
      endcase
    end
  end

  // Monitor: pops the scoreboard on each transfer and checks stall stability.
  initial begin
    bit          stalled = 1'b0;
    logic [18:0] held = '0;
    logic [18:0] got;
    logic [18:0] want;
    forever begin
      @(negedge clock);
      got = {px_x, px_y, px_colour, px_last};
      if (mon_en) begin
        if (stalled) begin
          chk("stall_valid", 32'(px_valid), 1);
          chk("stall_stable", 32'(got), 32'(held));
        end
        if (px_valid && px_ready) begin
          popped++;
          if (exp_q.size() == 0) begin
            chk("unexpected_pixel", 32'(got), 32'h7ffff);
          end else begin
            want = exp_q.pop_front();
            chk("pixel", 32'(got), 32'(want));
          end
        end
        stalled = px_valid && !px_ready;
        held    = got;
      end else begin
        stalled = 1'b0;
      end
    end
  end

  task automatic wait_clear(input bit plot_during, output int n);
    n = 0;
    while (clearing === 1'b1 && n < 25000) begin
      n++;
      if (plot_during && n == 19000) begin
        plot = 1'b1; x = 8'd0; y = 7'd0; colour = 3'd7;
      end else begin
        plot = 1'b0;
      end
      @(negedge clock);
    end
    plot = 1'b0;
  endtask

  task automatic do_plot(input int px, input int py, input int c);
    @(negedge clock);
    plot = 1'b1; x = 8'(px); y = 7'(py); colour = 3'(c);
    @(negedge clock);
    plot = 1'b0;
    if (px < W && py < H) model[py*W + px] = 3'(c);
  endtask

  task automatic issue_read(input int x0, input int y0, input int w, input int h);
    int t = 0;
    int sx, sy;
    logic [2:0] c;
    @(negedge clock);
    while (rd_ready !== 1'b1 && t < 30000) begin
      @(negedge clock);
      t++;
    end
    if (t >= 30000) chk("rd_ready_wait", 32'(rd_ready), 1);
    rd_req = 1'b1; rd_x0 = 8'(x0); rd_y0 = 7'(y0); rd_w = 8'(w); rd_h = 7'(h);
    for (int j = 0; j < h; j++) begin
      for (int i = 0; i < w; i++) begin
        sx = x0 + i;
        sy = y0 + j;
        c  = (sx < W && sy < H) ? model[sy*W + sx] : 3'd0;
        exp_q.push_back({8'(sx), 7'(sy), c, (i == w - 1) && (j == h - 1)});
      end
    end
    @(negedge clock);
    rd_req = 1'b0;
  endtask

  task automatic drain(input int budget);
    int t = 0;
    while ((exp_q.size() != 0 || rd_ready !== 1'b1) && t < budget) begin
      @(negedge clock);
      t++;
    end
    chk("drain_left", 32'(exp_q.size()), 0);
    chk("drain_ready", 32'(rd_ready), 1);
  endtask

  initial begin
    int n;
    int base;
    foreach (model[i]) model[i] = 3'd0;

    reset = 1'b0;
    repeat (3) @(negedge clock);
    chk("reset_outputs", 32'({px_valid, px_last, px_x, px_y, px_colour, rd_ready, clearing}),
        32'({1'b0, 1'b0, 8'd0, 7'd0, 3'd0, 1'b0, 1'b1}));
    reset = 1'b1;
    wait_clear(1'b1, n);
    chk("clear_cycles", 32'(n), 19200);
    chk("ready_after_clear", 32'(rd_ready), 1);
    mon_en = 1'b1;

    // Full screen after clear: all zero, including the pixel plotted mid-sweep
    rmode = 0;
    issue_read(0, 0, W, H);
    drain(25000);

    // Two adjacent plots read back with latency check
    do_plot(10, 5, 5);
    do_plot(11, 5, 2);
    issue_read(10, 5, 2, 1);
    chk("latency_c1", 32'(px_valid), 0);
    @(negedge clock);
    chk("latency_c2", 32'(px_valid), 1);
    drain(50);

    // Bottom-right corner region crossing both edges, random back-pressure
    do_plot(158, 118, 3);
    do_plot(159, 118, 6);
    do_plot(158, 119, 1);
    do_plot(159, 119, 7);
    do_plot(200, 10, 7);
    rmode = 1;
    issue_read(158, 118, 4, 3);
    drain(200);
    issue_read(40, 11, 1, 1);
    drain(50);

    // 1,0,0 ready pattern on an 8-pixel row
    for (int i = 0; i < 8; i++) do_plot(i, 0, int'($urandom_range(0, 7)));
    base  = popped;
    tcnt  = 0;
    rmode = 2;
    issue_read(0, 0, 8, 1);
    drain(200);
    repeat (3) @(negedge clock);
    chk("toggle_count", 32'(popped - base), 8);

    // Zero-width request is swallowed
    rmode = 0;
    issue_read(0, 0, 0, 5);
    chk("zero_ready", 32'(rd_ready), 1);
    chk("zero_valid", 32'(px_valid), 0);
    repeat (4) @(negedge clock);
    chk("zero_valid_later", 32'(px_valid), 0);

    // Randomized regions, plots and back-pressure
    for (int r = 0; r < 25; r++) begin
      for (int p = 0; p < 3; p++)
        do_plot(int'($urandom_range(0, 170)), int'($urandom_range(0, 127)), int'($urandom_range(0, 7)));
      rmode = int'($urandom_range(0, 2));
      issue_read(int'($urandom_range(0, 255)), int'($urandom_range(0, 127)),
                 int'($urandom_range(1, 12)), int'($urandom_range(1, 5)));
      drain(2000);
    end

    // Reset in the middle of a full-screen read
    rmode = 0;
    issue_read(0, 0, W, H);
    repeat (300) @(negedge clock);
    reset  = 1'b0;
    mon_en = 1'b0;
    @(negedge clock);
    chk("abort_valid", 32'(px_valid), 0);
    chk("abort_clearing", 32'(clearing), 1);
    exp_q.delete();
    @(negedge clock);
    reset = 1'b1;
    wait_clear(1'b0, n);
    chk("reclear_cycles", 32'(n), 19200);
    foreach (model[i]) model[i] = 3'd0;
    mon_en = 1'b1;
    issue_read(8, 4, 6, 3);
    drain(100);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
